ks_pipe_adder: RTL and testbench

//  Parametrised, pipelined Kogge-Stone adder/subtractor. Generalises the fixed 16-bit prefix

---
 rtl/ks_pipe_adder_pkg.sv | 39 +++
 rtl/ks_prefix_stage.sv | 70 +++++++
 rtl/ks_pipe_adder.sv | 143 ++++++++++++++
 tb/tb_ks_pipe_adder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pipe_adder_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder: level/span arithmetic,
// prefix cell equations and cell classification.
package ks_pipe_adder_pkg;

    typedef enum logic [1:0] {
        CELL_BUF,
        CELL_GRAY,
        CELL_BLACK
    } ks_cell_e;

    function automatic int unsigned ks_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned ks_span(input int unsigned level);
        return 32'd1 << (level - 1);
    endfunction

    function automatic logic ks_gen(input logic g_hi, input logic p_hi, input logic g_lo);
        return g_hi | (p_hi & g_lo);
    endfunction

    function automatic logic ks_prop(input logic p_hi, input logic p_lo);
        return p_hi & p_lo;
    endfunction

    // Bits whose lower operand is already fully resolved only need G (gray cell).
    function automatic ks_cell_e ks_cell_kind(input int unsigned bit_idx, input int unsigned span);
        if (bit_idx < span) return CELL_BUF;
        else if (bit_idx < 2 * span) return CELL_GRAY;
        else return CELL_BLACK;
    endfunction

endpackage

// File: rtl/ks_prefix_stage.sv
// One Kogge-Stone prefix level (gray/black/buffer cells) with its pipeline register.
// The load enable comes from the top-level ready chain.
module ks_prefix_stage
    import ks_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SPAN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0] i_pp,
    input  logic             i_cin,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_g,
    output logic [WIDTH-1:0] o_p,
    output logic [WIDTH-1:0] o_pp,
    output logic             o_cin
);

    logic             r_valid;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_pp;
    logic             r_cin;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        localparam ks_cell_e KIND = ks_cell_kind(i, SPAN);
        if (KIND == CELL_BLACK) begin : g_black
            assign w_g[i] = ks_gen(i_g[i], i_p[i], i_g[i-SPAN]);
            assign w_p[i] = ks_prop(i_p[i], i_p[i-SPAN]);
        end else if (KIND == CELL_GRAY) begin : g_gray
            assign w_g[i] = ks_gen(i_g[i], i_p[i], i_g[i-SPAN]);
            assign w_p[i] = i_p[i];
        end else begin : g_buf
            assign w_g[i] = i_g[i];
            assign w_p[i] = i_p[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_g     <= '0;
            r_p     <= '0;
            r_pp    <= '0;
            r_cin   <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_g   <= w_g;
                r_p   <= w_p;
                r_pp  <= i_pp;
                r_cin <= i_cin;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_g     = r_g;
    assign o_p     = r_p;
    assign o_pp    = r_pp;
    assign o_cin   = r_cin;

endmodule

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor: pre-process stage, log2(WIDTH) prefix
// stages and a sum stage, joined by a valid/ready chain with bubble collapsing.
module ks_pipe_adder
    import ks_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned L = ks_clog2(WIDTH);

    if (WIDTH < 4 || (32'd1 << L) != WIDTH) begin : g_bad_width
        $error("ks_pipe_adder: WIDTH must be a power of two >= 4");
    end

    // Index 0 is the pre-process register, index k the output of prefix level k.
    logic [L:0]            w_v;
    logic [L:0][WIDTH-1:0] w_g;
    logic [L:0][WIDTH-1:0] w_p;
    logic [L:0][WIDTH-1:0] w_pp;
    logic [L:0]            w_cin;
    logic [L+1:0]          w_rdy;
    logic [WIDTH-1:0]      w_p_unused;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [WIDTH-1:0] w_p_in;
    logic [WIDTH-1:0] w_g_in;
    logic [WIDTH-1:0] w_c;

    logic             r_s0_valid;
    logic [WIDTH-1:0] r_s0_g;
    logic [WIDTH-1:0] r_s0_p;
    logic             r_s0_cin;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    always_comb begin
        w_b_eff   = in_sub ? ~in_b : in_b;
        w_cin_eff = in_sub | in_cin;
        w_p_in    = in_a ^ w_b_eff;
        w_g_in    = in_a & w_b_eff;
        w_g_in[0] = ks_gen(w_g_in[0], w_p_in[0], w_cin_eff);
    end

    // A stage loads when empty or when its successor loads, so bubbles collapse.
    always_comb begin
        w_rdy      = '0;
        w_rdy[L+1] = !r_out_valid || out_ready;
        for (int unsigned i = 0; i <= L; i++) begin
            w_rdy[L-i] = !w_v[L-i] || w_rdy[L-i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_g     <= '0;
            r_s0_p     <= '0;
            r_s0_cin   <= 1'b0;
        end else if (w_rdy[0]) begin
            r_s0_valid <= in_valid;
            if (in_valid) begin
                r_s0_g   <= w_g_in;
                r_s0_p   <= w_p_in;
                r_s0_cin <= w_cin_eff;
            end
        end
    end

    assign w_v[0]   = r_s0_valid;
    assign w_g[0]   = r_s0_g;
    assign w_p[0]   = r_s0_p;
    assign w_pp[0]  = r_s0_p;
    assign w_cin[0] = r_s0_cin;

    for (genvar k = 1; k <= L; k++) begin : g_level
        ks_prefix_stage #(
            .WIDTH(WIDTH),
            .SPAN (ks_span(k))
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_rdy[k]),
            .i_valid(w_v[k-1]),
            .i_g    (w_g[k-1]),
            .i_p    (w_p[k-1]),
            .i_pp   (w_pp[k-1]),
            .i_cin  (w_cin[k-1]),
            .o_valid(w_v[k]),
            .o_g    (w_g[k]),
            .o_p    (w_p[k]),
            .o_pp   (w_pp[k]),
            .o_cin  (w_cin[k])
        );
    end

    // Group propagate is not needed past the last prefix level.
    assign w_p_unused = w_p[L];

    always_comb begin
        w_c = {w_g[L][WIDTH-2:0], w_cin[L]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_rdy[L+1]) begin
            r_out_valid <= w_v[L];
            if (w_v[L]) begin
                r_sum  <= w_pp[L] ^ w_c;
                r_cout <= w_g[L][WIDTH-1];
                r_ovf  <= w_g[L][WIDTH-1] ^ w_g[L][WIDTH-2];
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Self-checking bench for ks_pipe_adder at WIDTH 4, 16 and 64: directed vectors,
// streaming, backpressure and reset, against an integer-arithmetic reference.
module tb_ks_pipe_adder;

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cur;
    logic        tb_in_valid;
    logic        tb_cin;
    logic        tb_sub;
    logic        tb_out_ready;
    logic [63:0] tb_a;
    logic [63:0] tb_b;

    logic        v_in_ready  [3];
    logic        v_out_valid [3];
    logic [63:0] v_sum       [3];
    logic        v_cout      [3];
    logic        v_ovf       [3];

    int   total;
    int   bad;
    exp_t q[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int unsigned W = 4 << (2 * gi);
        logic [W-1:0] sum;
        ks_pipe_adder #(.WIDTH(W)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (tb_in_valid && (cur == gi)),
            .in_ready (v_in_ready[gi]),
            .in_a     (tb_a[W-1:0]),
            .in_b     (tb_b[W-1:0]),
            .in_cin   (tb_cin),
            .in_sub   (tb_sub),
            .out_valid(v_out_valid[gi]),
            .out_ready(tb_out_ready),
            .out_sum  (sum),
            .out_cout (v_cout[gi]),
            .out_ovf  (v_ovf[gi])
        );
        assign v_sum[gi] = 64'(sum);
    end

    function automatic int unsigned width_of(input int unsigned idx);
        return 4 << (2 * idx);
    endfunction

    function automatic logic [63:0] mask_of(input int unsigned w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: unsigned sum with carry, signed sum checked against the representable range.
    function automatic exp_t ref_add(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                     input logic cin, input logic sub);
        exp_t               e;
        logic [63:0]        m;
        logic [63:0]        am;
        logic [63:0]        bb;
        logic               c;
        logic [64:0]        u;
        logic signed [66:0] sa;
        logic signed [66:0] sb;
        logic signed [66:0] r;
        logic signed [66:0] lim;
        m   = mask_of(w);
        am  = a & m;
        bb  = (sub ? ~b : b) & m;
        c   = sub ? 1'b1 : cin;
        u   = {1'b0, am} + {1'b0, bb} + 65'(c);
        e.s = u[63:0] & m;
        e.co = u[w];
        sa  = $signed({3'b000, am});
        if (am[w-1]) sa = sa - (67'sd1 <<< w);
        sb  = $signed({3'b000, bb});
        if (bb[w-1]) sb = sb - (67'sd1 <<< w);
        r   = sa + sb + $signed({66'd0, c});
        lim = 67'sd1 <<< (w - 1);
        e.ov = (r >= lim) || (r < -lim);
        return e;
    endfunction

    function automatic logic [63:0] rand_operand(input int unsigned w);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = '1;
            1:       v = '0;
            2:       v = 64'd1 << (w - 1);
            3:       v = (64'd1 << (w - 1)) - 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v & mask_of(w);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_rand();
        tb_a   = rand_operand(width_of(cur));
        tb_b   = rand_operand(width_of(cur));
        tb_cin = 1'($urandom_range(0, 1));
        tb_sub = 1'($urandom_range(0, 1));
    endtask

    // One beat into an empty pipe: checks acceptance, latency and result.
    task automatic single(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic sub, input exp_t e, input string tag);
        int n;
        @(negedge clk);
        tb_a = a; tb_b = b; tb_cin = cin; tb_sub = sub;
        tb_in_valid = 1'b1;
        tb_out_ready = 1'b1;
        #1;
        chk({tag, " in_ready"}, 64'(v_in_ready[cur]), 64'd1);
        @(negedge clk);
        tb_in_valid = 1'b0;
        n = 1;
        while (!v_out_valid[cur] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'($clog2(width_of(cur)) + 2));
        chk({tag, " sum"}, v_sum[cur], e.s);
        chk({tag, " cout"}, 64'(v_cout[cur]), 64'(e.co));
        chk({tag, " ovf"}, 64'(v_ovf[cur]), 64'(e.ov));
    endtask

    task automatic stream(input int n, input int stall_at, input bit bp, input bit check_gaps,
                          input string tag);
        int          sent;
        int          got;
        int          cyc;
        int          gaps;
        bit          stall;
        exp_t        e;
        logic [63:0] h_sum;
        logic        h_co;
        logic        h_ov;
        q.delete();
        sent = 0; got = 0; cyc = 0; gaps = 0;
        h_sum = '0; h_co = 1'b0; h_ov = 1'b0;
        while (got < n && cyc < 3000) begin
            @(negedge clk);
            stall = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 3);
            tb_in_valid  = (sent < n) && (!bp || $urandom_range(0, 3) != 0);
            drive_rand();
            tb_out_ready = bp ? ($urandom_range(0, 3) != 0) : !stall;
            #1;
            if (stall) begin
                chk({tag, " stall in_ready"}, 64'(v_in_ready[cur]), 64'd0);
                chk({tag, " stall out_valid"}, 64'(v_out_valid[cur]), 64'd1);
                if (cyc == stall_at) begin
                    h_sum = v_sum[cur]; h_co = v_cout[cur]; h_ov = v_ovf[cur];
                end else begin
                    chk({tag, " hold sum"}, v_sum[cur], h_sum);
                    chk({tag, " hold cout"}, 64'(v_cout[cur]), 64'(h_co));
                    chk({tag, " hold ovf"}, 64'(v_ovf[cur]), 64'(h_ov));
                end
            end
            if (tb_in_valid && v_in_ready[cur]) begin
                q.push_back(ref_add(width_of(cur), tb_a, tb_b, tb_cin, tb_sub));
                sent++;
            end
            if (v_out_valid[cur] && tb_out_ready) begin
                if (q.size() == 0) begin
                    chk({tag, " unexpected beat"}, 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk({tag, " sum"}, v_sum[cur], e.s);
                    chk({tag, " cout"}, 64'(v_cout[cur]), 64'(e.co));
                    chk({tag, " ovf"}, 64'(v_ovf[cur]), 64'(e.ov));
                end
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            cyc++;
        end
        tb_in_valid = 1'b0;
        chk({tag, " beats out"}, 64'(got), 64'(n));
        chk({tag, " leftover"}, 64'(q.size()), 64'd0);
        if (check_gaps) chk({tag, " gaps"}, 64'(gaps), 64'd0);
    endtask

    task automatic reset_test(input string tag);
        int          seen;
        logic [63:0] a;
        logic [63:0] b;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tb_out_ready = 1'b1;
            tb_in_valid  = 1'b1;
            drive_rand();
        end
        @(negedge clk);
        tb_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, " rst in_ready"}, 64'(v_in_ready[cur]), 64'd1);
        chk({tag, " rst out_valid"}, 64'(v_out_valid[cur]), 64'd0);
        chk({tag, " rst sum"}, v_sum[cur], 64'd0);
        chk({tag, " rst cout"}, 64'(v_cout[cur]), 64'd0);
        chk({tag, " rst ovf"}, 64'(v_ovf[cur]), 64'd0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (v_out_valid[cur]) seen++;
        end
        chk({tag, " stale beats"}, 64'(seen), 64'd0);
        a = rand_operand(width_of(cur));
        b = rand_operand(width_of(cur));
        single(a, b, 1'b1, 1'b0, ref_add(width_of(cur), a, b, 1'b1, 1'b0), {tag, " post-rst"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        total = 0; bad = 0;
        cur = 1;
        tb_in_valid = 1'b0; tb_out_ready = 1'b0;
        tb_a = '0; tb_b = '0; tb_cin = 1'b0; tb_sub = 1'b0;
        rst = 1'b1;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[8] = '{16'h0000, 16'h8000, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("w%0d init in_ready", width_of(i)), 64'(v_in_ready[i]), 64'd1);
            chk($sformatf("w%0d init out_valid", width_of(i)), 64'(v_out_valid[i]), 64'd0);
            chk($sformatf("w%0d init sum", width_of(i)), v_sum[i], 64'd0);
            chk($sformatf("w%0d init cout", width_of(i)), 64'(v_cout[i]), 64'd0);
            chk($sformatf("w%0d init ovf", width_of(i)), 64'(v_ovf[i]), 64'd0);
        end

        cur = 1;
        for (int i = 0; i < 9; i++) begin
            e.s  = 64'(tbl[i].s);
            e.co = tbl[i].co;
            e.ov = tbl[i].ov;
            single(64'(tbl[i].a), 64'(tbl[i].b), tbl[i].cin, tbl[i].sub, e, $sformatf("vec%0d", i));
        end

        for (int unsigned w = 0; w < 3; w++) begin
            cur = w;
            reset_test($sformatf("w%0d", width_of(w)));
            stream(100, -1, 1'b0, 1'b1, $sformatf("w%0d b2b", width_of(w)));
            stream(30, 12, 1'b0, 1'b0, $sformatf("w%0d stall", width_of(w)));
            stream(200, -1, 1'b1, 1'b0, $sformatf("w%0d bp", width_of(w)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
